pwm_regulator: RTL and testbench
================================

# pwm_regulator

Multi-channel, parametrised PWM generator with closed-loop duty regulation, for driving several switching converter stages from one clock. Each channel compares a shared free-running ramp, optionally phase-interleaved, against its own duty register. The duty register steps up or down on a periodic regulation tick according to that channel's comparator feedback bit. Duty is saturated rather than wrapped, updated glitch-free at period boundaries, and can be overwritten from a host load port.

## Interface
- CHANNELS, 4: number of independent PWM channels (1..16).
- WIDTH, 11: ramp/duty width; PWM period = 2^WIDTH cycles.
- UPDATE_PERIOD, 10000: clock cycles between regulation ticks (≥2).
- STEP, 1: duty increment/decrement per tick (1..2^WIDTH-1).
- DUTY_MIN, 0: lower duty clamp; also the reset/soft-start duty.
- DUTY_MAX, 2^WIDTH-1: upper duty clamp (DUTY_MIN ≤ DUTY_MAX ≤ 2^WIDTH-1).
- INTERLEAVE, 1: 1 = channel i ramp offset by floor(i·2^WIDTH/CHANNELS); 0 = all channels in phase.
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run control; 0 = outputs off, state frozen.
- fb  in  CHANNELS  per-channel comparator feedback, asynchronous; 1 = output too high → decrease duty.
- load_valid  in  1  host duty write strobe (single cycle).
- load_ch  in  clog2(CHANNELS) (min 1)  channel to write; values ≥ CHANNELS ignored.
- load_duty  in  WIDTH  target duty to write (clamped).
- pwm  out  CHANNELS  PWM outputs, registered.
- en  out  1  driver enable, registered copy of enable.
- sat_hi  out  CHANNELS  registered: channel target == DUTY_MAX.
- sat_lo  out  CHANNELS  registered: channel target == DUTY_MIN.

## Operation
- Reset (async assert, sync release): ramp=0, tick counter=0, fb synchronisers=0, every target and active duty=DUTY_MIN, pwm=0, en=0, sat_lo=all 1 if DUTY_MIN==DUTY_MAX or always 1 at reset, sat_hi=1 only if DUTY_MIN==DUTY_MAX.
- Ramp: WIDTH-bit counter, +1 per cycle while enable=1, wraps 2^WIDTH-1 → 0. Channel ramp r_i = (ramp + offset_i) mod 2^WIDTH.
- PWM: pwm[i] <= (r_i < active_i). Duty 0 → constantly low; high time = active_i cycles per period.
- Shadow update: active_i <= target_i on the edge where r_i == 2^WIDTH-1, so each period uses exactly one duty value; no partial pulses.
- fb: each bit passes a 2-flop synchroniser before use.
- Regulation tick: counter 0..UPDATE_PERIOD-1, advances while enable=1; tick asserted in the cycle count == UPDATE_PERIOD-1, counter wraps to 0 on the same edge.
- On tick, per channel, computed in WIDTH+1 bits: fb_sync=1 → target = max(target − STEP, DUTY_MIN), with underflow treated as DUTY_MIN; fb_sync=0 → target = min(target + STEP, DUTY_MAX). No wrap-around under any STEP.
- Load: load_valid with load_ch < CHANNELS sets target[load_ch] = clamp(load_duty, DUTY_MIN, DUTY_MAX). Load wins over a simultaneous tick for that channel; other channels still take the tick.
- enable=0: ramp, tick counter, active duties held; pwm forced 0 next edge; en=0 next edge; loads still accepted into target. On re-enable, counting resumes from the held values.
- sat_hi/sat_lo are registered from the next-state target (same edge as target update).

## Timing
- pwm lags the ramp compare by 1 cycle; en lags enable by 1 cycle.
- fb to duty effect: 2 cycles of synchronisation, then the next tick, then the next period boundary of that channel.
- Load to target: 1 cycle. Load to pwm: next r_i wrap, then +1 cycle.
- reset_n assertion clears pwm/en immediately (async); the first ramp increment occurs on the first edge after release with enable=1.

## Test plan
- WIDTH=4, CHANNELS=2, INTERLEAVE=0, load duty 5 on ch0, enable → after the boundary, pwm[0] high exactly 5 of every 16 cycles; pwm[1] low (duty 0).
- UPDATE_PERIOD=8, STEP=3, DUTY_MAX=12, fb=0 held, start 0 → target 3,6,9,12,12 on successive ticks; sat_hi rises with 12; never wraps.
- fb=1 held from target 4, STEP=3, DUTY_MIN=0 → 1,0,0; sat_lo=1; no underflow wrap to 15.
- Load duty 10 mid-period while pwm high with duty 3 → current period still 3 cycles high, next period 10; load of 15 with DUTY_MAX=12 → target 12.
- INTERLEAVE=1, CHANNELS=2, both duty 4 → pwm[1] rising edges exactly 8 cycles after pwm[0]'s.
- Drop enable mid-pulse → pwm and en 0 next edge, counters frozen; assert reset_n low mid-operation → pwm=0, en=0 immediately; targets return to DUTY_MIN.

Source files
------------

// File: rtl/pwm_regulator.sv
// Multi-channel PWM generator with a shared (optionally phase-interleaved) ramp,
// per-channel saturating duty regulation on a periodic tick, and a host load port.
module pwm_regulator #(
    parameter int CHANNELS      = 4,
    parameter int WIDTH         = 11,
    parameter int UPDATE_PERIOD = 10000,
    parameter int STEP          = 1,
    parameter int DUTY_MIN      = 0,
    parameter int DUTY_MAX      = (1 << WIDTH) - 1,
    parameter int INTERLEAVE    = 1,
    localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [CHANNELS-1:0] fb,
    input  logic                load_valid,
    input  logic [CH_W-1:0]     load_ch,
    input  logic [WIDTH-1:0]    load_duty,
    output logic [CHANNELS-1:0] pwm,
    output logic                en,
    output logic [CHANNELS-1:0] sat_hi,
    output logic [CHANNELS-1:0] sat_lo
);

    localparam int                PERIOD    = 1 << WIDTH;
    localparam int                CNT_W     = $clog2(UPDATE_PERIOD);
    localparam logic [WIDTH-1:0]  RAMP_LAST = WIDTH'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(UPDATE_PERIOD - 1);
    localparam logic [WIDTH-1:0]  MIN_W     = WIDTH'(DUTY_MIN);
    localparam logic [WIDTH-1:0]  MAX_W     = WIDTH'(DUTY_MAX);
    localparam logic [WIDTH:0]    MIN_X     = (WIDTH + 1)'(DUTY_MIN);
    localparam logic [WIDTH:0]    MAX_X     = (WIDTH + 1)'(DUTY_MAX);
    localparam logic [WIDTH:0]    STEP_X    = (WIDTH + 1)'(STEP);
    localparam bit                HI_AT_RESET = (DUTY_MIN == DUTY_MAX);

    // Ramp offset for channel ch: evenly spread over one period when interleaving.
    function automatic logic [WIDTH-1:0] phase_offset(input int ch);
        if (INTERLEAVE == 0) return '0;
        return WIDTH'((longint'(ch) * longint'(PERIOD)) / longint'(CHANNELS));
    endfunction

    // Saturating arithmetic is done one bit wider so no STEP can wrap the duty.
    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] t);
        logic [WIDTH:0] t_x;
        t_x = {1'b0, t};
        if (t_x < MIN_X + STEP_X) return MIN_W;
        return WIDTH'(t_x - STEP_X);
    endfunction

    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] t);
        logic [WIDTH:0] sum;
        sum = {1'b0, t} + STEP_X;
        if (sum > MAX_X) return MAX_W;
        return WIDTH'(sum);
    endfunction

    logic [WIDTH-1:0]    ramp;
    logic [CNT_W-1:0]    tick_cnt;
    logic                tick;
    logic [CHANNELS-1:0] fb_meta;
    logic [CHANNELS-1:0] fb_sync;
    logic [WIDTH-1:0]    load_clamped;
    logic [WIDTH-1:0]    ch_ramp    [CHANNELS];
    logic [WIDTH-1:0]    target     [CHANNELS];
    logic [WIDTH-1:0]    target_nxt [CHANNELS];
    logic [WIDTH-1:0]    active     [CHANNELS];

    assign tick = enable && (tick_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ramp     <= '0;
            tick_cnt <= '0;
        end else if (enable) begin
            ramp     <= ramp + WIDTH'(1);
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fb_meta <= '0;
            fb_sync <= '0;
        end else begin
            fb_meta <= fb;
            fb_sync <= fb_meta;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_phase
        localparam logic [WIDTH-1:0] OFFSET = phase_offset(g);
        assign ch_ramp[g] = ramp + OFFSET;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        load_clamped = load_duty;
        if ({1'b0, load_duty} < MIN_X) begin
            load_clamped = MIN_W;
        end else if ({1'b0, load_duty} > MAX_X) begin
            load_clamped = MAX_W;
        end
    end

    // A host load beats the regulation tick on its own channel only.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            target_nxt[i] = target[i];
            if (load_valid && (int'(load_ch) == i)) begin
                target_nxt[i] = load_clamped;
            end else if (tick) begin
                target_nxt[i] = fb_sync[i] ? step_down(target[i]) : step_up(target[i]);
            end
        end
    end

    // NOTE: the duty arrays are a handful of flops, not RAM, so they take the reset like any register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                target[i] <= MIN_W;
                active[i] <= MIN_W;
            end
            pwm    <= '0;
            en     <= 1'b0;
            sat_hi <= {CHANNELS{HI_AT_RESET}};
            sat_lo <= '1;
        end else begin
            en <= enable;
            for (int i = 0; i < CHANNELS; i++) begin
                target[i] <= target_nxt[i];
                sat_hi[i] <= (target_nxt[i] == MAX_W);
                sat_lo[i] <= (target_nxt[i] == MIN_W);
                // Shadow copy on the channel's last ramp count keeps each period single-duty.
                if (enable && (ch_ramp[i] == RAMP_LAST)) begin
                    active[i] <= target[i];
                end
                pwm[i] <= enable && (ch_ramp[i] < active[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_regulator.sv
// Directed bench for pwm_regulator: three small instances (in-phase, interleaved,
// fast regulation tick) share stimulus; expected values are hand-derived constants.
module tb_pwm_regulator;

    localparam int W  = 4;
    localparam int CH = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [CH-1:0] fb = '0;
    logic          load_valid = 1'b0;
    logic [0:0]    load_ch = '0;
    logic [W-1:0]  load_duty = '0;

    logic [CH-1:0] pwm_a, sat_hi_a, sat_lo_a;
    logic [CH-1:0] pwm_b, sat_hi_b, sat_lo_b;
    logic [CH-1:0] pwm_r, sat_hi_r, sat_lo_r;
    logic          en_a, en_b, en_r;

    int tests = 0;
    int fails = 0;
    int a0, a1, b1;
    int first_b0, first_b1, next_b1, first_a1;
    logic prev_b0, prev_b1, prev_a1;

    always #5 clock = ~clock;

    pwm_regulator #(.CHANNELS(CH), .WIDTH(W), .UPDATE_PERIOD(4096), .STEP(3),
                    .DUTY_MIN(0), .DUTY_MAX(12), .INTERLEAVE(0)) u_a (
        .clock(clock), .reset_n(reset_n), .enable(enable), .fb(fb),
        .load_valid(load_valid), .load_ch(load_ch), .load_duty(load_duty),
        .pwm(pwm_a), .en(en_a), .sat_hi(sat_hi_a), .sat_lo(sat_lo_a));

    pwm_regulator #(.CHANNELS(CH), .WIDTH(W), .UPDATE_PERIOD(4096), .STEP(3),
                    .DUTY_MIN(0), .DUTY_MAX(12), .INTERLEAVE(1)) u_b (
        .clock(clock), .reset_n(reset_n), .enable(enable), .fb(fb),
        .load_valid(load_valid), .load_ch(load_ch), .load_duty(load_duty),
        .pwm(pwm_b), .en(en_b), .sat_hi(sat_hi_b), .sat_lo(sat_lo_b));

    pwm_regulator #(.CHANNELS(CH), .WIDTH(W), .UPDATE_PERIOD(8), .STEP(3),
                    .DUTY_MIN(0), .DUTY_MAX(12), .INTERLEAVE(0)) u_r (
        .clock(clock), .reset_n(reset_n), .enable(enable), .fb(fb),
        .load_valid(load_valid), .load_ch(load_ch), .load_duty(load_duty),
        .pwm(pwm_r), .en(en_r), .sat_hi(sat_hi_r), .sat_lo(sat_lo_r));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clocks; outputs are sampled 1 time unit after each rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic load(input logic [0:0] ch, input logic [W-1:0] d);
        load_ch    = ch;
        load_duty  = d;
        load_valid = 1'b1;
        step(1);
        load_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        enable     = 1'b0;
        fb         = '0;
        load_valid = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic window(input int n, output int c_a0, output int c_a1, output int c_b1);
        c_a0 = 0;
        c_a1 = 0;
        c_b1 = 0;
        repeat (n) begin
            step(1);
            c_a0 += int'(pwm_a[0]);
            c_a1 += int'(pwm_a[1]);
            c_b1 += int'(pwm_b[1]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_pwm",    32'(pwm_r),    32'd0);
        check("rst_en",     32'(en_r),     32'd0);
        check("rst_sat_lo", 32'(sat_lo_r), 32'd3);
        check("rst_sat_hi", 32'(sat_hi_r), 32'd0);

        // Duty 5 on ch0, in phase: no pulse until the first boundary, then 5/16
        load(1'b0, 4'd5);
        check("load5_target", 32'(u_a.target[0]), 32'd5);
        enable = 1'b1;
        check("en_before_edge", 32'(en_a), 32'd0);
        step(1);
        check("en_after_edge", 32'(en_a), 32'd1);
        check("pwm_first_cycle", 32'(pwm_a[0]), 32'd0);
        window(15, a0, a1, b1);
        check("first_period_highs", 32'(a0), 32'd0);
        step(1);
        check("first_high_cycle", 32'(pwm_a[0]), 32'd1);
        window(15, a0, a1, b1);
        check("period2_rest_highs", 32'(a0), 32'd4);
        window(16, a0, a1, b1);
        check("period3_highs_ch0", 32'(a0), 32'd5);
        check("period3_highs_ch1", 32'(a1), 32'd0);

        // Saturating climb with fb=0: 3,6,9,12,12
        do_reset();
        enable = 1'b1;
        step(7);
        check("reg_before_tick", 32'(u_r.target[0]), 32'd0);
        step(1);
        check("reg_tick1", 32'(u_r.target[0]), 32'd3);
        check("reg_tick1_sat_lo", 32'(sat_lo_r), 32'd0);
        step(8);
        check("reg_tick2", 32'(u_r.target[0]), 32'd6);
        step(8);
        check("reg_tick3", 32'(u_r.target[0]), 32'd9);
        check("reg_tick3_sat_hi", 32'(sat_hi_r), 32'd0);
        step(8);
        check("reg_tick4", 32'(u_r.target[0]), 32'd12);
        check("reg_tick4_sat_hi", 32'(sat_hi_r), 32'd3);
        step(8);
        check("reg_tick5_ch0", 32'(u_r.target[0]), 32'd12);
        check("reg_tick5_ch1", 32'(u_r.target[1]), 32'd12);

        // Saturating descent with fb=1 from 4: 1,0,0
        do_reset();
        fb = 2'b11;
        load(1'b0, 4'd4);
        step(3);
        enable = 1'b1;
        step(8);
        check("dn_tick1", 32'(u_r.target[0]), 32'd1);
        check("dn_tick1_sat_lo", 32'(sat_lo_r), 32'd2);
        step(8);
        check("dn_tick2", 32'(u_r.target[0]), 32'd0);
        check("dn_tick2_sat_lo", 32'(sat_lo_r), 32'd3);
        step(8);
        check("dn_tick3_no_wrap", 32'(u_r.target[0]), 32'd0);
        fb = '0;

        // Mid-period load: current period keeps duty 3, next uses 10
        do_reset();
        load(1'b0, 4'd3);
        enable = 1'b1;
        window(16, a0, a1, b1);
        check("mid_first_period", 32'(a0), 32'd0);
        step(1);
        check("mid_pulse_start", 32'(pwm_a[0]), 32'd1);
        load(1'b0, 4'd10);
        check("mid_load_target", 32'(u_a.target[0]), 32'd10);
        check("mid_pulse_second", 32'(pwm_a[0]), 32'd1);
        window(14, a0, a1, b1);
        check("mid_period_rest", 32'(a0), 32'd1);
        window(16, a0, a1, b1);
        check("mid_next_period", 32'(a0), 32'd10);
        load(1'b0, 4'd15);
        check("load15_clamped", 32'(u_a.target[0]), 32'd12);
        check("load15_sat_hi", 32'(sat_hi_a[0]), 32'd1);

        // Drop enable mid-pulse: outputs off next edge, ramp frozen, loads accepted
        step(1);
        check("pre_disable_pwm", 32'(pwm_a[0]), 32'd1);
        enable = 1'b0;
        step(1);
        check("disable_pwm", 32'(pwm_a[0]), 32'd0);
        check("disable_en", 32'(en_a), 32'd0);
        check("disable_ramp", 32'(u_a.ramp), 32'd2);
        step(5);
        check("frozen_ramp", 32'(u_a.ramp), 32'd2);
        check("frozen_pwm", 32'(pwm_a[0]), 32'd0);
        load(1'b0, 4'd7);
        check("disabled_load", 32'(u_a.target[0]), 32'd7);
        enable = 1'b1;
        step(1);
        check("resume_ramp", 32'(u_a.ramp), 32'd3);
        check("resume_pwm", 32'(pwm_a[0]), 32'd1);

        // Asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_pwm", 32'(pwm_a), 32'd0);
        check("async_rst_en", 32'(en_a), 32'd0);
        check("async_rst_target", 32'(u_a.target[0]), 32'd0);
        check("async_rst_sat_lo", 32'(sat_lo_a), 32'd3);
        step(1);

        // Interleave: ch1 ramp offset 8, both duty 4
        do_reset();
        load(1'b0, 4'd4);
        load(1'b1, 4'd4);
        enable = 1'b1;
        first_b0 = -1;
        first_b1 = -1;
        next_b1  = -1;
        first_a1 = -1;
        prev_b0  = 1'b0;
        prev_b1  = 1'b0;
        prev_a1  = 1'b0;
        b1 = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (pwm_b[0] && !prev_b0 && first_b0 < 0) first_b0 = k;
            if (pwm_b[1] && !prev_b1) begin
                if (first_b1 < 0) first_b1 = k;
                else if (first_b0 >= 0 && next_b1 < 0) next_b1 = k;
            end
            if (pwm_a[1] && !prev_a1 && first_a1 < 0) first_a1 = k;
            if (k >= 17 && k <= 32) b1 += int'(pwm_b[1]);
            prev_b0 = pwm_b[0];
            prev_b1 = pwm_b[1];
            prev_a1 = pwm_a[1];
        end
        check("il_first_rise_ch1", 32'(first_b1), 32'd9);
        check("il_first_rise_ch0", 32'(first_b0), 32'd17);
        check("il_ch1_after_ch0",  32'(next_b1), 32'd25);
        check("il_ch1_highs",      32'(b1), 32'd4);
        check("inphase_rise_ch1",  32'(first_a1), 32'd17);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
